// File: rtl/wide_alu_seq.sv
// -----------------------------------------------------------------------------
// wide_alu_seq
//
// Performs 16-bit (2*DW) add, subtract, AND and OR using an external
// combinational DW-bit ALU. Each wide operation is split into byte-wide ALU
// operations, one per clock:
//   LO  : low bytes
//   HI  : high bytes
//   FIX : only for add/sub when the low byte produced a carry/borrow. The
//         carry/borrow is folded into the high byte by adding or subtracting 1.
//
// Handshake toward the controller:
//   Start/Busy/Done. Start is accepted only in IDLE, which is the only state
//   with Busy=0. Busy stays high from the cycle after acceptance through the
//   Done cycle. Done is a one-cycle pulse, and WRslt/WCarry/WZero are valid
//   in that cycle. Start is ignored while Busy=1, including in the Done cycle,
//   and is not queued.
//
// Ports:
//   Clk       clock; all state changes on the rising edge
//   Reset     synchronous, active-high; aborts any operation in progress
//   Start     operation request
//   WOp       00 add16, 01 sub16, 10 and16, 11 or16
//   WA, WB    wide operands
//   Busy      an operation is in flight
//   Done      one-cycle pulse; the result outputs are valid
//   WRslt     wide result; holds until the next Done or Reset
//   WCarry    add: carry out; sub: borrow (A<B unsigned); logic ops: 0
//   WZero     WRslt == 0
//   AluOp     to the ALU: 000 add, 010 AND, 011 OR, 100 sub
//   AluA/B    to the ALU operand inputs
//   AluRslt   from the ALU result
//   AluSCo    from the ALU carry (add) or borrow (sub)
//   dbg_state current FSM state, for observation only
// -----------------------------------------------------------------------------
module wide_alu_seq #(
    parameter int DW = 8
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic [1:0]      WOp,
    input  logic [2*DW-1:0] WA,
    input  logic [2*DW-1:0] WB,
    output logic            Busy,
    output logic            Done,
    output logic [2*DW-1:0] WRslt,
    output logic            WCarry,
    output logic            WZero,
    output logic [2:0]      AluOp,
    output logic [DW-1:0]   AluA,
    output logic [DW-1:0]   AluB,
    input  logic [DW-1:0]   AluRslt,
    input  logic            AluSCo,
    output logic [2:0]      dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LO   = 3'd1,
        S_HI   = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [1:0] W_ADD = 2'b00;
    localparam logic [1:0] W_SUB = 2'b01;
    localparam logic [1:0] W_AND = 2'b10;
    localparam logic [1:0] W_OR  = 2'b11;

    localparam logic [2:0] A_ADD = 3'b000;
    localparam logic [2:0] A_AND = 3'b010;
    localparam logic [2:0] A_OR  = 3'b011;
    localparam logic [2:0] A_SUB = 3'b100;

    state_t state;
    state_t state_next;

    // Latched request.
    logic [2*DW-1:0] a_q;
    logic [2*DW-1:0] b_q;
    logic [1:0]      op_q;

    // Partial results and carries.
    logic [DW-1:0]   r_lo;
    logic [DW-1:0]   r_hi;
    logic            c0;   // low-byte carry/borrow; selects the FIX step
    logic            c1;   // high-byte carry/borrow
    logic            c2;   // carry/borrow produced by the FIX step

    // Visible result registers.
    logic [2*DW-1:0] rslt_q;
    logic            carry_q;
    logic            zero_q;

    // Add and sub are the only ops that propagate a carry between bytes.
    logic            is_arith;
    logic [2:0]      mapped_op;
    logic [2:0]      fix_op;
    logic [2*DW-1:0] hi_word;

    assign is_arith = (op_q == W_ADD) || (op_q == W_SUB);

    always_comb begin
        mapped_op = A_ADD;
        case (op_q)
            W_ADD:   mapped_op = A_ADD;
            W_SUB:   mapped_op = A_SUB;
            W_AND:   mapped_op = A_AND;
            W_OR:    mapped_op = A_OR;
            default: mapped_op = A_ADD;
        endcase
    end

    // The FIX step adds a low-byte carry, or subtracts a low-byte borrow.
    assign fix_op = (op_q == W_SUB) ? A_SUB : A_ADD;

    // The full word as it will appear once this cycle's ALU result is captured
    // as the high byte. This is used in both HI and FIX.
    assign hi_word = {AluRslt, r_lo};

    // ------------------------------------------------------------------
    // Next-state and ALU drive. The ALU drive is decoded from the
    // registered state only, so the ALU inputs never depend on Start or
    // on the wide operand inputs.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        AluOp      = A_ADD;
        AluA       = '0;
        AluB       = '0;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    state_next = S_LO;
                end
            end
            S_LO: begin
                AluOp      = mapped_op;
                AluA       = a_q[DW-1:0];
                AluB       = b_q[DW-1:0];
                state_next = S_HI;
            end
            S_HI: begin
                AluOp      = mapped_op;
                AluA       = a_q[2*DW-1:DW];
                AluB       = b_q[2*DW-1:DW];
                state_next = (is_arith && c0) ? S_FIX : S_DONE;
            end
            S_FIX: begin
                AluOp      = fix_op;
                AluA       = r_hi;
                AluB       = DW'(1);
                state_next = S_DONE;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers.
    // The result registers load on the edge that enters DONE, so they are
    // already valid during the Done cycle. They change at no other time.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= W_ADD;
            r_lo    <= '0;
            r_hi    <= '0;
            c0      <= 1'b0;
            c1      <= 1'b0;
            c2      <= 1'b0;
            rslt_q  <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        a_q  <= WA;
                        b_q  <= WB;
                        op_q <= WOp;
                        c0   <= 1'b0;
                        c1   <= 1'b0;
                        c2   <= 1'b0;
                    end
                end
                S_LO: begin
                    r_lo <= AluRslt;
                    c0   <= is_arith & AluSCo;
                end
                S_HI: begin
                    r_hi <= AluRslt;
                    c1   <= is_arith & AluSCo;
                    if (state_next == S_DONE) begin
                        rslt_q  <= hi_word;
                        carry_q <= (is_arith & AluSCo) | c2;
                        zero_q  <= (hi_word == '0);
                    end
                end
                S_FIX: begin
                    r_hi    <= AluRslt;
                    c2      <= AluSCo;
                    rslt_q  <= hi_word;
                    carry_q <= c1 | AluSCo;
                    zero_q  <= (hi_word == '0);
                end
                default: begin
                end
            endcase
        end
    end

    assign Busy      = (state != S_IDLE);
    assign Done      = (state == S_DONE);
    assign WRslt     = rslt_q;
    assign WCarry    = carry_q;
    assign WZero     = zero_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_wide_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_wide_alu_seq
//
// Testbench for wide_alu_seq. A behavioural 8-bit ALU drives AluRslt/AluSCo.
//
// The bench applies three groups of operations:
//   - directed vectors from a table
//   - randomized operations checked against a wide-arithmetic reference
//   - hand-written sequences for reset-abort and Start-while-busy
//
// Inputs are driven on the falling edge and outputs are sampled there too.
//
// Handshake: an operation is requested by holding Start=1 across one rising
// edge while Busy=0. Done marks the single cycle in which WRslt, WCarry and
// WZero are valid.
// -----------------------------------------------------------------------------
module tb_wide_alu_seq;

    localparam int DW = 8;
    localparam int W  = 2 * DW;

    logic          Clk;
    logic          Reset;
    logic          Start;
    logic [1:0]    WOp;
    logic [W-1:0]  WA;
    logic [W-1:0]  WB;
    logic          Busy;
    logic          Done;
    logic [W-1:0]  WRslt;
    logic          WCarry;
    logic          WZero;
    logic [2:0]    AluOp;
    logic [DW-1:0] AluA;
    logic [DW-1:0] AluB;
    logic [DW-1:0] AluRslt;
    logic          AluSCo;
    logic [2:0]    dbg_state;

    wide_alu_seq #(.DW(DW)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .WOp       (WOp),
        .WA        (WA),
        .WB        (WB),
        .Busy      (Busy),
        .Done      (Done),
        .WRslt     (WRslt),
        .WCarry    (WCarry),
        .WZero     (WZero),
        .AluOp     (AluOp),
        .AluA      (AluA),
        .AluB      (AluB),
        .AluRslt   (AluRslt),
        .AluSCo    (AluSCo),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- behavioural 8-bit ALU ----------------
    logic [DW:0] alu_sum;
    always_comb begin
        alu_sum = '0;
        AluRslt = '0;
        AluSCo  = 1'b0;
        case (AluOp)
            3'b000: begin
                alu_sum = {1'b0, AluA} + {1'b0, AluB};
                AluRslt = alu_sum[DW-1:0];
                AluSCo  = alu_sum[DW];
            end
            3'b100: begin
                AluRslt = AluA - AluB;
                AluSCo  = (AluA < AluB);
            end
            3'b010: AluRslt = AluA & AluB;
            3'b011: AluRslt = AluA | AluB;
            default: begin
            end
        endcase
    end

    // ---------------- scoreboard ----------------
    int total;
    int bad;
    int accepted;
    int done_seen;
    logic [W+1:0] exp_q[$];   // {carry, zero, result}

    always @(negedge Clk) begin
        if (Done) done_seen++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] alu_code(input logic [1:0] op);
        case (op)
            2'b00:   return 3'b000;
            2'b01:   return 3'b100;
            2'b10:   return 3'b010;
            default: return 3'b011;
        endcase
    endfunction

    // Reference model working on whole 16-bit words.
    // Latency is 4 when an add/sub low byte carries or borrows, otherwise 3.
    task automatic ref_model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                             output logic [W-1:0] r, output logic c, output logic z,
                             output int lat);
        int unsigned full;
        lat = 3;
        c   = 1'b0;
        case (op)
            2'b00: begin
                full = int'(a) + int'(b);
                r = full[W-1:0];
                c = (full > 32'hFFFF);
                if (int'(a[7:0]) + int'(b[7:0]) > 255) lat = 4;
            end
            2'b01: begin
                r = a - b;
                c = (a < b);
                if (a[7:0] < b[7:0]) lat = 4;
            end
            2'b10: r = a & b;
            default: r = a | b;
        endcase
        z = (r == '0);
    endtask

    // One full operation. In noisy mode, the operand inputs and Start are
    // scrambled while busy, and Start is held high in the Done cycle.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] er, input logic ec, input logic ez,
                          input int elat, input bit noisy);
        int cyc;
        logic [W+1:0] e;
        exp_q.push_back({ec, ez, er});
        @(negedge Clk);
        Start = 1'b1; WOp = op; WA = a; WB = b;
        @(negedge Clk);
        Start = 1'b0;
        accepted++;
        cyc = 1;
        chk("lo_aluop", 32'(AluOp), 32'(alu_code(op)));
        chk("lo_alua", 32'(AluA), 32'(a[7:0]));
        chk("lo_alub", 32'(AluB), 32'(b[7:0]));
        while (!Done && cyc < 8) begin
            chk("busy_inflight", 32'(Busy), 32'd1);
            if (cyc == 2) begin
                chk("hi_alua", 32'(AluA), 32'(a[15:8]));
                chk("hi_alub", 32'(AluB), 32'(b[15:8]));
            end
            if (noisy) begin
                Start = 1'($urandom_range(0, 1));
                WOp   = 2'($urandom);
                WA    = W'($urandom);
                WB    = W'($urandom);
            end
            @(negedge Clk);
            cyc++;
        end
        if (!Done) begin
            chk("done_timeout", 32'd0, 32'd1);
            Start = 1'b0;
        end else begin
            chk("latency", 32'(cyc), 32'(elat));
            chk("busy_done", 32'(Busy), 32'd1);
            e = exp_q.pop_front();
            chk("wrslt", 32'(WRslt), 32'(e[W-1:0]));
            chk("wcarry", 32'(WCarry), 32'(e[W+1]));
            chk("wzero", 32'(WZero), 32'(e[W]));
            if (noisy) Start = 1'b1;   // Start sampled in Done must be ignored
            @(negedge Clk);
            Start = 1'b0;
            chk("busy_after", 32'(Busy), 32'd0);
            chk("done_pulse", 32'(Done), 32'd0);
            chk("wrslt_hold", 32'(WRslt), 32'(e[W-1:0]));
            chk("idle_aluop", 32'(AluOp), 32'd0);
            chk("idle_alua", 32'(AluA), 32'd0);
            chk("idle_alub", 32'(AluB), 32'd0);
        end
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         c;
        logic         z;
        int           lat;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rr;
        logic cc, zz;
        int ll;

        vecs[0] = '{2'b00, 16'h12FF, 16'h0001, 16'h1300, 1'b0, 1'b0, 4};
        vecs[1] = '{2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 4};
        vecs[2] = '{2'b01, 16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b0, 4};
        vecs[3] = '{2'b01, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 4};
        vecs[4] = '{2'b10, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 3};
        vecs[5] = '{2'b11, 16'hF0F0, 16'h3C3C, 16'hFCFC, 1'b0, 1'b0, 3};
        vecs[6] = '{2'b00, 16'h1234, 16'h0001, 16'h1235, 1'b0, 1'b0, 3};
        vecs[7] = '{2'b01, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b1, 3};
        vecs[8] = '{2'b00, 16'hFF00, 16'h0100, 16'h0000, 1'b1, 1'b1, 3};
        vecs[9] = '{2'b10, 16'h0F0F, 16'hF0F0, 16'h0000, 1'b0, 1'b1, 3};

        total = 0; bad = 0; accepted = 0; done_seen = 0;
        Reset = 1'b1; Start = 1'b0; WOp = 2'b00; WA = 16'hA5A5; WB = 16'h5A5A;

        // reset state
        repeat (2) @(negedge Clk);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_wrslt", 32'(WRslt), 32'd0);
        chk("rst_wcarry", 32'(WCarry), 32'd0);
        chk("rst_wzero", 32'(WZero), 32'd0);
        chk("rst_aluop", 32'(AluOp), 32'd0);
        chk("rst_alua", 32'(AluA), 32'd0);
        chk("rst_alub", 32'(AluB), 32'd0);
        Reset = 1'b0;

        // directed table
        for (int i = 0; i < 10; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].c, vecs[i].z,
                   vecs[i].lat, 1'b0);

        // Start pulses while busy and in the Done cycle must be ignored
        run_op(2'b00, 16'h12FF, 16'h0001, 16'h1300, 1'b0, 1'b0, 4, 1'b1);
        run_op(2'b11, 16'hF0F0, 16'h3C3C, 16'hFCFC, 1'b0, 1'b0, 3, 1'b1);

        // reset during HI aborts with no Done pulse
        @(negedge Clk);
        Start = 1'b1; WOp = 2'b00; WA = 16'h12FF; WB = 16'h0001;
        @(negedge Clk);          // LO
        Start = 1'b0;
        @(negedge Clk);          // HI
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_done", 32'(Done), 32'd0);
        chk("abort_wrslt", 32'(WRslt), 32'd0);
        chk("abort_wcarry", 32'(WCarry), 32'd0);
        chk("abort_wzero", 32'(WZero), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            chk("abort_quiet", 32'({Busy, Done}), 32'd0);
        end
        run_op(2'b01, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 4, 1'b0);

        // randomized against the reference model
        for (int i = 0; i < 60; i++) begin
            logic [1:0] op;
            logic [W-1:0] a, b;
            op = 2'($urandom_range(0, 3));
            a  = W'($urandom);
            b  = W'($urandom);
            if (i % 5 == 0) b[7:0] = 8'hFF - a[7:0] + 8'(op == 2'b00);  // force low carry on adds
            ref_model(op, a, b, rr, cc, zz, ll);
            run_op(op, a, b, rr, cc, zz, ll, (i % 3 == 0));
        end

        repeat (3) @(negedge Clk);
        chk("done_count", 32'(done_seen), 32'(accepted));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wide_alu_seq.md
Name: wide_alu_seq

Overview:
- Multi-cycle sequencer directly upstream of the 8-bit ALU; executes 16-bit add, sub, AND and OR by issuing byte-wide operations to the ALU one per cycle.
- Sole driver of ALU op and operand inputs; consumes ALU result and carry/borrow in the same cycle (ALU is combinational).
- Start/Busy/Done handshake toward the controller.

Parameters:
- DW, 8, ALU datapath width; wide operand/result width is 2*DW.

Ports:
- Clk  input  1  clock, all state on rising edge
- Reset  input  1  synchronous, active-high
- Start  input  1  request; accepted only when Busy=0
- WOp  input  2  00 add16, 01 sub16, 10 and16, 11 or16
- WA  input  2*DW  operand A
- WB  input  2*DW  operand B
- Busy  output  1  high from acceptance through the Done cycle
- Done  output  1  one-cycle pulse, result valid
- WRslt  output  2*DW  wide result
- WCarry  output  1  add: carry out; sub: borrow (A<B unsigned); logic: 0
- WZero  output  1  WRslt==0
- AluOp  output  3  to ALU: 000 add, 010 AND, 011 OR, 100 sub
- AluA  output  DW  to ALU DatA
- AluB  output  DW  to ALU DatB
- AluRslt  input  DW  from ALU Rslt
- AluSCo  input  1  from ALU SCo (add carry / sub borrow)

Behaviour:
- Reset (synchronous, active-high): state IDLE; Busy=0, Done=0, WRslt=0, WCarry=0, WZero=0; internal operand, partial-result and carry registers cleared. Reset in any state aborts the operation; no Done pulse is produced.
- ALU drive is registered-state decoded: in IDLE and DONE, AluOp=000, AluA=0, AluB=0.
- Op mapping: add16->000, sub16->100, and16->010, or16->011.
- States:
  - IDLE: Start=1 -> latch WA, WB, WOp; Busy=1; go LO. Start=0 -> stay.
  - LO: drive low bytes and mapped op; capture RLo<=AluRslt. For add/sub, c0<=AluSCo; for logic ops, c0<=0. Go HI.
  - HI: drive high bytes and mapped op; capture RHi<=AluRslt, c1<=AluSCo (0 for logic ops). If add/sub with c0=1, go FIX; else go DONE.
  - FIX: AluA=RHi, AluB=8'h01, op 000 (add16) or 100 (sub16); capture RHi<=AluRslt, c2<=AluSCo. Go DONE. c2 is cleared on every acceptance.
  - DONE: Done=1 for this cycle only; WRslt={RHi,RLo}; WCarry=c1|c2; WZero=({RHi,RLo}==0); go IDLE, Busy drops the following cycle.
- Latency, counting Start sampled at edge 0:
  - Done is high in cycle 3 with no FIX and cycle 4 with FIX.
  - Busy is high in cycles 1..3 or 1..4.
- Start while Busy=1 is ignored; no queueing. Start sampled in the DONE cycle is also ignored. Back-to-back throughput is therefore one op per 4 or 5 cycles.
- WRslt, WCarry and WZero update only in DONE and hold until the next DONE or Reset.
- c1 and c2 are never both 1: the high sum cannot overflow twice.
- Unsigned arithmetic throughout; results wrap modulo 2^(2*DW).

Test Plan:
- Add with low carry: WOp=00, WA=16'h12FF, WB=16'h0001 -> FIX taken; Done in cycle 4; WRslt=16'h1300, WCarry=0, WZero=0.
- Add full overflow: WA=16'hFFFF, WB=16'h0001 -> WRslt=16'h0000, WCarry=1, WZero=1, Done in cycle 4.
- Sub with and without borrow:
  - WA=16'h1000, WB=16'h0001 -> WRslt=16'h0FFF, WCarry=0.
  - WA=16'h0000, WB=16'h0001 -> WRslt=16'hFFFF, WCarry=1.
- Logic ops: WOp=10, WA=16'hF0F0, WB=16'h3C3C -> WRslt=16'h3030, Done in cycle 3. WOp=11 on the same operands -> WRslt=16'hFCFC, WCarry=0.
- Handshake and sequencing:
  - Pulse Start again in cycles 1..3 with different operands -> ignored; result matches the first op.
  - Exactly one Done pulse per accepted op.
  - ALU ports read 000/0/0 in IDLE.
- Reset mid-op: assert Reset during HI -> next cycle Busy=0, Done=0, WRslt=0, no Done pulse. A new Start after Reset completes correctly.
